fifo2pattern_unpack: RTL and testbench
======================================

# fifo2pattern_unpack

Read-side unpacker for the 256-bit RAM staging FIFO. It streams a frame of 256-bit words out of a standard-mode FIFO (rd_en, then valid), splits each word into eight 32-bit beats of two 16-bit lanes, and presents them on a valid/ready stream to the pattern/DAC output path. Its beat ordering and lane mapping are the inverse of the ADC capture packer: beat k of a word is bits [255-32k -: 32], with ch1 in the upper half and ch2 in the lower half.

## Interface
Parameters:
- FRAME_WORDS, 64: 256-bit words per frame; legal range 1..65535.
- LANE_W, 16: width of each output lane; fixed at 16, so one beat is 32 bits.

Ports:
- clk  in  1  single clock for the FIFO read side and the output stream.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start request; sampled only in IDLE.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse after the last beat of a frame is accepted.
- underrun  out  1  sticky starvation flag; cleared by an accepted start.
- fifo_rd_en  out  1  FIFO read strobe.
- fifo_dout  in  256  FIFO data; meaningful only when fifo_valid is high.
- fifo_valid  in  1  FIFO data valid, arriving one cycle after fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- out_valid  out  1  an output beat is present.
- out_ready  in  1  the downstream sink accepts the beat.
- out_ch1  out  16  lane 1 of the beat (upper half of the beat).
- out_ch2  out  16  lane 2 of the beat (lower half of the beat).
- out_last  out  1  marks the final beat of the frame.

## Operation
- States:
  - IDLE → RUN when start is high. On this transition req_cnt, beat_total and underrun are cleared.
  - RUN → DRAIN when req_cnt reaches FRAME_WORDS.
  - DRAIN → IDLE on the handshake of the last beat.
- start is ignored outside IDLE.
- Storage:
  - A one-word holding buffer (buf, buf_full).
  - A 256-bit shift register with a 4-bit beat count sh_cnt (0..8).
  - One pend bit marking a read in flight.
- Read issue (combinational): fifo_rd_en = (state==RUN) & !fifo_empty & !pend & !buf_full & (req_cnt < FRAME_WORDS).
  - On fifo_rd_en: pend is set and req_cnt is incremented.
  - On fifo_valid: buf takes fifo_dout, buf_full is set and pend is cleared.
  - fifo_valid while pend is low is ignored.
- Shift register load: it loads from buf, clearing buf_full and setting sh_cnt=8, when either:
  - sh_cnt==0, or
  - sh_cnt==1 and the output handshake occurs in the same cycle (no bubble).
- Output:
  - out_valid = (sh_cnt != 0).
  - {out_ch1, out_ch2} = sh[255:224].
  - On handshake (out_valid & out_ready): sh shifts left by 32, sh_cnt decrements, and beat_total increments.
  - out_last = out_valid & (beat_total == 8*FRAME_WORDS-1).
- Underrun: set when state==RUN, sh_cnt==0, buf_full==0 and out_ready==1. It stays set until the next accepted start.
- done pulses one cycle after the last handshake, coincident with busy falling.
- Reset clears every register. It does not flush the FIFO.

## Timing
- Reset values: busy 0, done 0, underrun 0, fifo_rd_en 0, out_valid 0, out_ch1/out_ch2 0, out_last 0. State is IDLE.
- Start-up latency, with start high in cycle 0 and the FIFO non-empty:
  - cycle 1: fifo_rd_en.
  - cycle 2: fifo_valid.
  - cycle 3: buf_full.
  - cycle 4: first out_valid.
- Throughput: sustained 1 beat per cycle with out_ready held high and the FIFO non-empty. The 2-cycle refill hides under the 8-beat word.
- Output beats are held stable while out_valid & !out_ready.
- Empty FIFO mid-frame: reads stall and output gaps appear. There is no data loss.
- FRAME_WORDS=1: exactly 8 beats, with out_last on beat 7.
- beat_total is 19 bits wide and never wraps within a frame.

## Structure
- A shared package holds LANE_W, BEAT_W=32, BEATS_PER_WORD=8, WORD_W=256, and the state encoding (IDLE=0, RUN=1, DRAIN=2).
- One natural sub-module: word_shifter, which contains sh, sh_cnt, the load and shift logic, and out_valid. The FSM, read control and counters stay at the top level.

## Test plan
- Reset mid-frame (after 5 beats): all outputs return to 0 immediately and state is IDLE. A new start replays correctly from the next FIFO word.
- FRAME_WORDS=2, words 0x0001_0002…0x000F_0010 and 0x0011_0012…0x001F_0020, out_ready=1:
  - first beat has ch1=0x0001, ch2=0x0002.
  - 16 beats are output, with out_last only on beat 15 (ch1=0x001F, ch2=0x0020).
  - done pulses the following cycle.
- Random out_ready at 30% duty: beats are unchanged while stalled, and the sequence matches the golden unpacked stream.
- FIFO empty after word 0 for 20 cycles, out_ready=1:
  - underrun sets after beat 7.
  - the frame completes once data resumes.
  - underrun stays high until the next start.
- start pulsed again while busy: ignored, and the frame beat count is unchanged.

Source files
------------

// File: rtl/fifo2pattern_unpack_pkg.sv
// fifo2pattern_unpack_pkg
// Shared widths and the FSM encoding for the 256-bit FIFO read-side unpacker.
//   LANE_W         width of one output lane (ch1 / ch2)
//   BEAT_W         one output beat = two lanes
//   BEATS_PER_WORD beats carried by one FIFO word
//   WORD_W         FIFO word width
//   REQ_CNT_W      word request counter width (holds FRAME_WORDS up to 65535)
//   BEAT_CNT_W     frame beat counter width (8*65535-1 fits, never wraps)
package fifo2pattern_unpack_pkg;

  localparam int LANE_W         = 16;
  localparam int BEAT_W         = 2 * LANE_W;
  localparam int BEATS_PER_WORD = 8;
  localparam int WORD_W         = BEAT_W * BEATS_PER_WORD;
  localparam int REQ_CNT_W      = 17;
  localparam int BEAT_CNT_W     = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo2pattern_unpack_word_shifter.sv
// fifo2pattern_unpack_word_shifter
// Holds one 256-bit word and presents it MSB-first as eight 32-bit beats.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   load_word   word waiting in the holding buffer
//   load_avail  holding buffer is full
//   out_ready   downstream accepts the current beat
//   load        buffer word is taken this cycle (caller clears its buffer)
//   out_valid   a beat is present (beat count non-zero)
//   beat        current beat, sh[255:224]
module fifo2pattern_unpack_word_shifter
  import fifo2pattern_unpack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] load_word,
  input  logic              load_avail,
  input  logic              out_ready,
  output logic              load,
  output logic              out_valid,
  output logic [BEAT_W-1:0] beat
);

  logic [WORD_W-1:0] sh;
  logic [3:0]        sh_cnt;

  assign out_valid = (sh_cnt != 4'd0);
  assign beat      = sh[WORD_W-1 -: BEAT_W];

  // Reloading while the final beat is being accepted keeps the stream
  // gap-free across word boundaries.
  assign load = load_avail &
                ((sh_cnt == 4'd0) | ((sh_cnt == 4'd1) & out_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh     <= '0;
      sh_cnt <= 4'd0;
    end else if (load) begin
      sh     <= load_word;
      sh_cnt <= 4'(BEATS_PER_WORD);
    end else if (out_valid && out_ready) begin
      sh     <= sh << BEAT_W;
      sh_cnt <= sh_cnt - 4'd1;
    end
  end

endmodule

// File: rtl/fifo2pattern_unpack.sv
// fifo2pattern_unpack
// Streams one frame of FRAME_WORDS 256-bit words out of a standard-mode FIFO
// and emits them as 32-bit beats {ch1, ch2}, beat k = word[255-32k -: 32].
// Output handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready low the beat
// and out_last are held unchanged; out_valid never drops without a transfer.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           frame request, honoured only in IDLE
//   busy / done     frame active / one-cycle pulse after the last beat
//   underrun        sticky: sink was ready but no data was available in RUN
//   fifo_rd_en      FIFO read strobe; fifo_dout/fifo_valid return a cycle later
//   fifo_empty      FIFO empty flag
//   out_valid/out_ready/out_ch1/out_ch2/out_last  output beat stream
//   dbg_state       current FSM state
module fifo2pattern_unpack
  import fifo2pattern_unpack_pkg::*;
#(
  parameter int FRAME_WORDS = 64,
  parameter int LANE_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              underrun,
  output logic              fifo_rd_en,
  input  logic [WORD_W-1:0] fifo_dout,
  input  logic              fifo_valid,
  input  logic              fifo_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_ch1,
  output logic [LANE_W-1:0] out_ch2,
  output logic              out_last,
  output state_t            dbg_state
);

  localparam logic [REQ_CNT_W-1:0]  REQ_LIMIT = REQ_CNT_W'(FRAME_WORDS);
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT =
    BEAT_CNT_W'(BEATS_PER_WORD * FRAME_WORDS - 1);

  state_t                  state;
  logic [REQ_CNT_W-1:0]    req_cnt;
  logic [BEAT_CNT_W-1:0]   beat_total;
  logic                    pend;
  logic                    buf_full;
  logic [WORD_W-1:0]       word_buf;
  logic                    sh_load;
  logic                    hs;
  logic [BEAT_W-1:0]       beat;

  // Only one read may be outstanding and only into an empty buffer, so the
  // FIFO never returns a word there is nowhere to put.
  assign fifo_rd_en = (state == ST_RUN) & ~fifo_empty & ~pend & ~buf_full &
                      (req_cnt < REQ_LIMIT);

  assign hs                 = out_valid & out_ready;
  assign out_last           = out_valid & (beat_total == LAST_BEAT);
  assign {out_ch1, out_ch2} = beat;
  assign busy               = (state != ST_IDLE);
  assign dbg_state          = state;

  fifo2pattern_unpack_word_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load_word  (word_buf),
    .load_avail (buf_full),
    .out_ready  (out_ready),
    .load       (sh_load),
    .out_valid  (out_valid),
    .beat       (beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_cnt    <= '0;
      beat_total <= '0;
      pend       <= 1'b0;
      buf_full   <= 1'b0;
      word_buf   <= '0;
      underrun   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (fifo_rd_en) begin
        pend    <= 1'b1;
        req_cnt <= req_cnt + 1'b1;
      end

      // A stray fifo_valid without a read in flight is dropped. Fill and
      // load cannot coincide: a fill needs an empty buffer, a load a full one.
      if (fifo_valid && pend) begin
        word_buf <= fifo_dout;
        buf_full <= 1'b1;
        pend     <= 1'b0;
      end else if (sh_load) begin
        buf_full <= 1'b0;
      end

      if (hs) beat_total <= beat_total + 1'b1;

      if ((state == ST_RUN) && !out_valid && !buf_full && out_ready)
        underrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_RUN;
            req_cnt    <= '0;
            beat_total <= '0;
            underrun   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (req_cnt == REQ_LIMIT) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (hs && out_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo2pattern_unpack.sv
module tb_fifo2pattern_unpack;
  import fifo2pattern_unpack_pkg::*;

  localparam int FW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (FRAME_WORDS = 2) ----------------
  logic              start, busy, done, underrun, fifo_rd_en;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_valid, fifo_empty;
  logic              out_valid, out_ready, out_last;
  logic [15:0]       out_ch1, out_ch2;
  state_t            dbg_state;

  fifo2pattern_unpack #(.FRAME_WORDS(FW), .LANE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .underrun(underrun), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_valid(fifo_valid), .fifo_empty(fifo_empty), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch1(out_ch1), .out_ch2(out_ch2),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  // ---------------- DUT (FRAME_WORDS = 1) ----------------
  logic              start1, busy1, done1, underrun1, fifo_rd_en1;
  logic [WORD_W-1:0] fifo_dout1;
  logic              fifo_valid1, fifo_empty1;
  logic              out_valid1, out_ready1, out_last1;
  logic [15:0]       out_ch1_1, out_ch2_1;
  state_t            dbg_state1;

  fifo2pattern_unpack #(.FRAME_WORDS(1), .LANE_W(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .underrun(underrun1), .fifo_rd_en(fifo_rd_en1), .fifo_dout(fifo_dout1),
    .fifo_valid(fifo_valid1), .fifo_empty(fifo_empty1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_ch1(out_ch1_1), .out_ch2(out_ch2_1),
    .out_last(out_last1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  logic [WORD_W-1:0] fq[$];      // FIFO model contents
  logic [31:0]       exp_q[$];   // expected beats, in order
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc;
  bit    done_exp;
  int    frame_beats;
  int    hs_cnt;
  logic [31:0] first_beat, last_beat;
  bit    got_first;
  int    first_valid_cyc;
  bit    done_seen;
  bit    rd_prev, rd_prev1;
  int    beats1, last_idx1;
  bit    done1_seen;
  logic [31:0] first1;

  typedef struct {
    logic [15:0] base;
    int          ready_pct;
    bit          restart_mid;
    logic [15:0] f1, f2, l1, l2;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  function automatic logic [WORD_W-1:0] make_word(input logic [15:0] base);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) w[255-16*i -: 16] = base + 16'(i + 1);
    return w;
  endfunction

  task automatic push_word(input logic [WORD_W-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: sample at the falling edge, answer FIFO reads after the
  // rising edge.
  task automatic tick();
    logic [31:0]       cur;
    logic [WORD_W-1:0] w;
    @(negedge clk);
    cur = {out_ch1, out_ch2};
    check("done_pulse", {31'd0, done}, {31'd0, done_exp});
    done_exp = 1'b0;
    if (done) done_seen = 1'b1;
    if (out_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got 0x%0h expected no beat", cur);
      end else begin
        check("beat", cur, exp_q[0]);
      end
      if (out_ready) begin
        check("last_flag", {31'd0, out_last}, {31'd0, frame_beats == 8*FW-1});
        if (!got_first) begin first_beat = cur; got_first = 1'b1; end
        last_beat = cur;
        hs_cnt++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (frame_beats == 8*FW-1) begin
          done_exp    = 1'b1;
          frame_beats = 0;
        end else begin
          frame_beats++;
        end
      end
    end
    rd_prev = fifo_rd_en;
    if (out_valid1 && out_ready1) begin
      if (beats1 == 0) first1 = {out_ch1_1, out_ch2_1};
      if (out_last1) last_idx1 = beats1;
      beats1++;
    end
    if (done1) done1_seen = 1'b1;
    rd_prev1 = fifo_rd_en1;
    @(posedge clk);
    #1;
    cyc++;
    if (rd_prev && fq.size() > 0) begin
      w = fq.pop_front();
      fifo_dout  = w;
      fifo_valid = 1'b1;
      for (int k = 0; k < 8; k++) exp_q.push_back(w[255-32*k -: 32]);
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty  = (fq.size() == 0);
    fifo_valid1 = rd_prev1;
  endtask

  task automatic run_frame(input int pct, input bit restart_mid,
                           input logic [15:0] f1, input logic [15:0] f2,
                           input logic [15:0] l1, input logic [15:0] l2);
    got_first = 1'b0; hs_cnt = 0; first_valid_cyc = -1; done_seen = 1'b0;
    cyc = 0;
    start = 1'b1;
    out_ready = ($urandom_range(0, 99) < pct);
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("underrun_cleared", {31'd0, underrun}, 32'd0);
    check("rd_en_cycle1", {31'd0, fifo_rd_en}, 32'd1);
    for (int i = 0; i < 3000 && !done_seen; i++) begin
      out_ready = ($urandom_range(0, 99) < pct);
      start = (restart_mid && i == 10);
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("frame_done_seen", {31'd0, done_seen}, 32'd1);
    check("frame_beat_count", 32'(hs_cnt), 32'd16);
    check("first_beat", first_beat, {f1, f2});
    check("last_beat", last_beat, {l1, l2});
    check("first_valid_latency", 32'(first_valid_cyc), 32'd4);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 100, 1'b0, 16'h0001, 16'h0002, 16'h001F, 16'h0020};
    vecs[1] = '{16'h0100,  30, 1'b1, 16'h0101, 16'h0102, 16'h011F, 16'h0120};
    vecs[2] = '{16'hFFE0,  70, 1'b0, 16'hFFE1, 16'hFFE2, 16'hFFFF, 16'h0000};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    fifo_dout = '0; fifo_valid = 1'b0; fifo_empty = 1'b1;
    start1 = 1'b0; out_ready1 = 1'b1; fifo_valid1 = 1'b0; fifo_empty1 = 1'b0;
    fifo_dout1 = make_word(16'h0500);
    done_exp = 1'b0; frame_beats = 0; hs_cnt = 0; cyc = 0;
    beats1 = 0; last_idx1 = -1; done1_seen = 1'b0; first1 = '0;
    first_valid_cyc = -1; got_first = 1'b0; done_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_lanes", {out_ch1, out_ch2}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // Starvation: one word, sink held off until the first beat, then a gap.
    done_seen = 1'b0; hs_cnt = 0;
    push_word(make_word(16'h0200));
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("uf_first_valid", {31'd0, out_valid}, 32'd1);
    check("uf_before_gap", {31'd0, underrun}, 32'd0);
    out_ready = 1'b1;
    repeat (20) tick();
    check("uf_beats_word0", 32'(hs_cnt), 32'd8);
    check("uf_set_in_gap", {31'd0, underrun}, 32'd1);
    check("uf_still_busy", {31'd0, busy}, 32'd1);
    push_word(make_word(16'h0210));
    for (int i = 0; i < 200 && !done_seen; i++) tick();
    check("uf_frame_done", {31'd0, done_seen}, 32'd1);
    check("uf_beats_total", 32'(hs_cnt), 32'd16);
    check("uf_sticky_idle", {31'd0, underrun}, 32'd1);
    out_ready = 1'b0;
    tick();

    // Table of whole frames.
    for (int v = 0; v < 3; v++) begin
      push_word(make_word(vecs[v].base));
      push_word(make_word(vecs[v].base + 16'h0010));
      run_frame(vecs[v].ready_pct, vecs[v].restart_mid,
                vecs[v].f1, vecs[v].f2, vecs[v].l1, vecs[v].l2);
      tick();
    end

    // Reset after five beats, then replay from the next FIFO word.
    push_word(make_word(16'h0300));
    push_word(make_word(16'h0310));
    push_word(make_word(16'h0320));
    push_word(make_word(16'h0330));
    hs_cnt = 0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && hs_cnt < 5; i++) tick();
    check("mid_beats_before_rst", 32'(hs_cnt), 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_lanes", {out_ch1, out_ch2}, 32'd0);
    check("mid_rst_last", {31'd0, out_last}, 32'd0);
    check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    frame_beats = 0; done_exp = 1'b0; fifo_valid = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_frame(100, 1'b0, 16'h0321, 16'h0322, 16'h033F, 16'h0340);
    tick();

    // Single-word frame on the second instance.
    beats1 = 0; last_idx1 = -1; done1_seen = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (20) tick();
    check("fw1_beats", 32'(beats1), 32'd8);
    check("fw1_last_index", 32'(last_idx1), 32'd7);
    check("fw1_done", {31'd0, done1_seen}, 32'd1);
    check("fw1_first_beat", first1, 32'h0501_0502);
    check("fw1_idle", {31'd0, busy1}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
